fir_result_reader: RTL
======================

// Module: fir_result_reader
// PURPOSE
//  Reader side of the FIR result interface. Arms one FIR run via a start pulse.
//  Captures every 21-bit result word the FIR writes (result bus + write strobe) into a FIFO.
//  Presents the words to the host on a valid/ready stream, optionally saturated to OUT_W.
//  Counts captured words, reports run completion, overflow and count mismatch.
//  Sits between the FIR top level and the host/CDC output path.
// PARAMETERS
//  WYNIK_W   21   FIR result width (signed, two's complement)
//  OUT_W     16   host data width; OUT_W==WYNIK_W passes through, OUT_W<WYNIK_W saturates
//  DEPTH     16   FIFO depth in words; power of two, >=2
//  CNT_W     15   result counter width; matches the FIR repeat-count width
// PORTS
//  clk              in   1        system clock, single clock domain
//  rst_n            in   1        synchronous reset, active low
//  host_go          in   1        1-cycle request to start a run; ignored unless IDLE
//  host_ile_razy    in   CNT_W    expected result count, sampled on accepted host_go
//  r_start          out  1        1-cycle start pulse to the FIR
//  r_pracuje        in   1        FIR busy flag
//  r_done           in   1        FIR done pulse
//  r_wyj_wr         in   1        FIR result write strobe
//  r_probka_wynik   in   WYNIK_W  FIR result word, valid with r_wyj_wr
//  out_data         out  OUT_W    result to host
//  out_valid        out  1        out_data valid
//  out_ready        in   1        host accepts out_data
//  busy             out  1        high from accepted host_go until the FIN cycle
//  done             out  1        1-cycle pulse in FIN
//  overflow         out  1        sticky; a write arrived with the FIFO full and no pop
//  cnt_err          out  1        sticky; captured count != host_ile_razy at r_done
//  wynik_cnt        out  CNT_W    results captured in the current/last run
// BEHAVIOUR
//  Reset: r_start=0, out_valid=0, out_data=0, busy=0, done=0, overflow=0, cnt_err=0,
//  wynik_cnt=0, FIFO empty, FSM=IDLE. Reset mid-run drops FIFO contents and counters.
//  FSM states: IDLE, START, RUN, DRAIN, FIN.
//   IDLE --host_go--> START: latch host_ile_razy; clear wynik_cnt, overflow, cnt_err.
//   START: r_start=1 for exactly this cycle; next state is always RUN.
//   RUN: capture writes. r_done -> DRAIN. cnt_err is set if the count including any
//    write in the same cycle is != the latched value.
//   DRAIN: FIFO empty -> FIN. Late writes are still captured and counted.
//   FIN: done=1, busy=0 this cycle; next state is IDLE.
//  Capture rules:
//   - r_wyj_wr is honoured in START, RUN and DRAIN, and ignored in IDLE and FIN.
//   - wynik_cnt increments on every honoured write, including dropped ones, and
//     saturates at all-ones.
//  FIFO rules:
//   - Push on an honoured write. Pop when out_valid && out_ready.
//   - Push while full with a simultaneous pop is accepted. Push while full with no
//     pop is dropped and sets overflow.
//   - Pointers wrap modulo DEPTH. A log2(DEPTH)+1 occupancy counter distinguishes
//     full from empty.
//  Output timing:
//   - Registered output; a write at cycle N into an empty FIFO gives out_valid at N+1.
//   - out_data and out_valid stay stable while out_valid && !out_ready.
//   - Back-to-back pops sustain 1 word/cycle.
//  Width rules: when OUT_W<WYNIK_W, saturate the signed value to
//   [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Otherwise pass the value through unchanged.
//  host_go outside IDLE is ignored. r_done outside RUN is ignored.
// STRUCTURE
//  fir_pkg: WYNIK_W, ILE_RAZY_W constants; typedef enum rr_state_t {IDLE,START,RUN,DRAIN,FIN}.
//  Sub-module fir_result_fifo: synchronous FIFO (DEPTH, width WYNIK_W) with
//  push/pop/full/empty. Saturation and FSM live in fir_result_reader.
// TESTING
//  1 host_go, ile_razy=4; 4 writes 0x00010,0x00020,0x1FFFF0,0x00030, out_ready=1 ->
//    r_start pulse in the cycle after go; out_data 0x0010,0x0020,0xFFF0,0x0030, each 1 cycle after its write;
//    done pulse; cnt_err=0.
//  2 OUT_W=16; writes 0x0F0000, 0x100000 -> out_data 0x7FFF, 0x8000.
//  3 DEPTH=16, out_ready=0, 17 writes -> overflow=1, wynik_cnt=17;
//    then out_ready=1 -> exactly 16 words out, in write order.
//  4 ile_razy=5, FIR writes 3 then r_done -> cnt_err=1, done after FIFO drains.
//  5 full FIFO, push and pop in the same cycle -> no overflow, occupancy unchanged, order kept.
//  6 rst_n=0 for 1 cycle mid-RUN with 3 words queued -> all outputs at reset values;
//    next host_go runs a clean run.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the FIR result reader slice.
package fir_pkg;
    localparam int WYNIK_W    = 21;
    localparam int ILE_RAZY_W = 15;

    typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, FIN} rr_state_t;
endpackage

// File: rtl/fir_result_reader_if.sv
// FIR-side result bus and host-side output stream of the result reader.
interface fir_wynik_if #(parameter int WYNIK_W = fir_pkg::WYNIK_W) ();
    logic               r_start;
    logic               r_pracuje;
    logic               r_done;
    logic               r_wyj_wr;
    logic [WYNIK_W-1:0] r_probka_wynik;

    modport master (input r_start, output r_pracuje, r_done, r_wyj_wr, r_probka_wynik);
    modport slave  (output r_start, input r_pracuje, r_done, r_wyj_wr, r_probka_wynik);
endinterface

interface fir_out_if #(parameter int OUT_W = 16) ();
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, out_valid, input out_ready);
    modport slave  (input out_data, out_valid, output out_ready);
endinterface

// File: rtl/fir_result_fifo.sv
// Synchronous FIFO with an occupancy counter; read data is the head word, read combinationally.
module fir_result_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_occ;

    assign o_full  = (r_occ == (AW+1)'(DEPTH));
    assign o_empty = (r_occ == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Caller guarantees push only when not full or popping, pop only when not empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)      r_occ <= r_occ + 1'b1;
            else if (!i_push && i_pop) r_occ <= r_occ - 1'b1;
        end
    end
endmodule

// File: rtl/fir_result_reader.sv
// Arms one FIR run, queues its result words and streams them to the host with optional saturation.
//  state | meaning
//  IDLE  | waiting for host_go
//  START | one-cycle start pulse to the FIR
//  RUN   | capturing results until r_done
//  DRAIN | waiting for the FIFO to empty
//  FIN   | one-cycle done pulse
module fir_result_reader
    import fir_pkg::*;
#(
    parameter int WYNIK_W = fir_pkg::WYNIK_W,
    parameter int OUT_W   = 16,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = ILE_RAZY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             host_go,
    input  logic [CNT_W-1:0] host_ile_razy,
    fir_wynik_if.slave       fir,
    fir_out_if.master        hst,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             cnt_err,
    output logic [CNT_W-1:0] wynik_cnt
);
    rr_state_t          r_state;
    rr_state_t          w_state_nxt;
    logic [CNT_W-1:0]   r_ile_razy;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_overflow;
    logic               r_cnt_err;
    logic               w_cap;
    logic               w_wr;
    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic [WYNIK_W-1:0] w_rdata;
    logic [OUT_W-1:0]   w_sat;
    logic               w_unused;

    assign w_unused = fir.r_pracuje;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (host_go) w_state_nxt = START;
            START:   w_state_nxt = RUN;
            RUN:     if (fir.r_done) w_state_nxt = DRAIN;
            DRAIN:   if (w_empty) w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fir.r_start = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        w_cap       = 1'b0;
        unique case (r_state)
            START:   begin fir.r_start = 1'b1; busy = 1'b1; w_cap = 1'b1; end
            RUN:     begin busy = 1'b1; w_cap = 1'b1; end
            DRAIN:   begin busy = 1'b1; w_cap = 1'b1; end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    assign w_wr      = fir.r_wyj_wr && w_cap;
    assign w_pop     = !w_empty && hst.out_ready;
    assign w_push    = w_wr && (!w_full || w_pop);
    // Dropped writes still count, so the count reflects what the FIR actually produced.
    assign w_cnt_nxt = (w_wr && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ile_razy <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_cnt_err  <= 1'b0;
        end else if (r_state == IDLE && host_go) begin
            r_ile_razy <= host_ile_razy;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_cnt_err  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_wr && w_full && !w_pop) r_overflow <= 1'b1;
            if (r_state == RUN && fir.r_done && (w_cnt_nxt != r_ile_razy)) r_cnt_err <= 1'b1;
        end
    end

    fir_result_fifo #(.DEPTH(DEPTH), .W(WYNIK_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (fir.r_probka_wynik),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    generate
        if (OUT_W < WYNIK_W) begin : g_sat
            logic w_in_range;
            assign w_in_range = (w_rdata[WYNIK_W-1:OUT_W-1] ==
                                 {(WYNIK_W-OUT_W+1){w_rdata[WYNIK_W-1]}});
            assign w_sat = w_in_range ? w_rdata[OUT_W-1:0] :
                           {w_rdata[WYNIK_W-1], {(OUT_W-1){~w_rdata[WYNIK_W-1]}}};
        end else if (OUT_W == WYNIK_W) begin : g_pass
            assign w_sat = w_rdata;
        end else begin : g_sext
            assign w_sat = {{(OUT_W-WYNIK_W){w_rdata[WYNIK_W-1]}}, w_rdata};
        end
    endgenerate

    // Head memory is not reset, so data is forced to zero whenever nothing is valid.
    assign hst.out_valid = !w_empty;
    assign hst.out_data  = w_empty ? '0 : w_sat;
    assign overflow      = r_overflow;
    assign cnt_err       = r_cnt_err;
    assign wynik_cnt     = r_cnt;
endmodule
